gf_serial_mul_ctrl: RTL and testbench

GF_SERIAL_MUL_CTRL -- requirements
Module: gf_serial_mul_ctrl

---
 rtl/gf_serial_mul_ctrl.sv | 123 ++++++++++++
 tb/tb_gf_serial_mul_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_serial_mul_ctrl.sv
// Digit-serial GF(2^m) multiplier with a valid/ready handshake.
// One shared multiply step consumes DIGITAL bits of b (MSB first) per clock.
module gf_serial_mul_ctrl #(
    parameter int DATA_WIDTH = 163,
    parameter int DIGITAL    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] g,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int NUM_DIGITS = (DATA_WIDTH + DIGITAL - 1) / DIGITAL;
    localparam int PAD_W      = NUM_DIGITS * DIGITAL;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] t_q, t_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] g_q, g_d;
    logic [PAD_W-1:0]      b_q, b_d;

    // DIGITAL rounds of: t <- t*x mod (x^m + g), then add a if the digit bit is set.
    function automatic logic [DATA_WIDTH-1:0] mul_step(
        input logic [DATA_WIDTH-1:0] t_in,
        input logic [DIGITAL-1:0]    digit,
        input logic [DATA_WIDTH-1:0] a_in,
        input logic [DATA_WIDTH-1:0] g_in
    );
        logic [DATA_WIDTH-1:0] acc;
        acc = t_in;
        for (int i = DIGITAL - 1; i >= 0; i--) begin
            acc = {acc[DATA_WIDTH-2:0], 1'b0} ^ (acc[DATA_WIDTH-1] ? g_in : {DATA_WIDTH{1'b0}});
            acc = acc ^ (digit[i] ? a_in : {DATA_WIDTH{1'b0}});
        end
        return acc;
    endfunction

    // Next-state and datapath update; b is kept as a shift register so the
    // current digit is always its top DIGITAL bits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        a_d     = a_q;
        g_d     = g_q;
        b_d     = b_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    g_d     = g;
                    b_d     = PAD_W'(b);
                    t_d     = {DATA_WIDTH{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                t_d = mul_step(t_q, b_q[PAD_W-1 -: DIGITAL], a_q, g_q);
                b_d = b_q << DIGITAL;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and accumulator, synchronously reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            t_q     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
        end
    end

    // Operand holding registers; contents are don't-care until loaded.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        g_q <= g_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign result    = t_q;

endmodule

// File: tb/tb_gf_serial_mul_ctrl.sv
// Directed-vector and random bench for gf_serial_mul_ctrl at DIGITAL=4 and DIGITAL=5.
module tb_gf_serial_mul_ctrl;

    localparam int W = 163;
    localparam logic [W-1:0] GPOLY = 163'hC9;
    localparam logic [W-1:0] B162  = 163'd1 << 162;
    localparam logic [W-1:0] B161  = 163'd1 << 161;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] g;
        logic [W-1:0] exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         iv4, iv5;
    logic         out_ready;
    logic [W-1:0] a, b, g;
    logic         ir4, ir5, ov4, ov5, busy4, busy5;
    logic [W-1:0] res4, res5;

    int n_checks;
    int n_errors;

    gf_serial_mul_ctrl #(.DATA_WIDTH(W), .DIGITAL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a), .b(b), .g(g), .out_valid(ov4), .out_ready(out_ready),
        .result(res4), .busy(busy4)
    );

    gf_serial_mul_ctrl #(.DATA_WIDTH(W), .DIGITAL(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5),
        .a(a), .b(b), .g(g), .out_valid(ov5), .out_ready(out_ready),
        .result(res5), .busy(busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd163();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Schoolbook product followed by top-down reduction with x^163 = g.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] gp);
        logic [325:0] p;
        p = '0;
        for (int i = 0; i < W; i++)
            if (y[i]) p = p ^ (326'(x) << i);
        for (int k = 2 * W - 2; k >= W; k--)
            if (p[k]) begin
                p[k] = 1'b0;
                p = p ^ (326'(gp) << (k - W));
            end
        return p[W-1:0];
    endfunction

    task automatic start_op(input bit sel, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic [W-1:0] gg);
        @(negedge clk);
        a = aa; b = bb; g = gg;
        if (sel) iv5 = 1'b1; else iv4 = 1'b1;
        chk("in_ready_idle", W'(sel ? ir5 : ir4), W'(1));
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0; iv5 = 1'b0;
        a = rnd163(); b = rnd163(); g = rnd163();
        chk("busy_run", W'(sel ? busy5 : busy4), W'(1));
        chk("in_ready_run", W'(sel ? ir5 : ir4), W'(0));
    endtask

    task automatic wait_done(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? ov5 : ov4) && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_check(input bit sel, input logic [W-1:0] aa, input logic [W-1:0] bb,
                             input logic [W-1:0] gg, input logic [W-1:0] exp);
        int lat;
        start_op(sel, aa, bb, gg);
        wait_done(sel, lat);
        chk("latency", W'(lat), W'(sel ? 33 : 41));
        chk("result", sel ? res5 : res4, exp);
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after", W'(sel ? ir5 : ir4), W'(1));
        chk("out_valid_after", W'(sel ? ov5 : ov4), W'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [W-1:0] ra, rb, rg, saved;
        int lat;

        vecs[0] = '{a: 163'd1,  b: 163'd1,      g: GPOLY, exp: 163'd1};
        vecs[1] = '{a: B162,    b: 163'd2,      g: GPOLY, exp: 163'hC9};
        vecs[2] = '{a: B162,    b: 163'd4,      g: GPOLY, exp: 163'h192};
        vecs[3] = '{a: B162 | 163'd1, b: 163'd2, g: GPOLY, exp: 163'hCB};
        vecs[4] = '{a: 163'd3,  b: 163'd3,      g: GPOLY, exp: 163'd5};
        vecs[5] = '{a: 163'hFF, b: 163'h100,    g: GPOLY, exp: 163'hFF00};
        vecs[6] = '{a: B161,    b: 163'd6,      g: GPOLY, exp: B162 | 163'hC9};
        vecs[7] = '{a: 163'd1,  b: B162 | 163'd1, g: GPOLY, exp: B162 | 163'd1};
        vecs[8] = '{a: 163'h1234_5678_9ABC, b: 163'd0, g: GPOLY, exp: 163'd0};
        vecs[9] = '{a: 163'd0,  b: 163'hDEAD_BEEF, g: GPOLY, exp: 163'd0};

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; iv4 = 1'b0; iv5 = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; g = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready4", W'(ir4), W'(1));
        chk("rst_out_valid4", W'(ov4), W'(0));
        chk("rst_busy4", W'(busy4), W'(0));
        chk("rst_result4", res4, '0);
        chk("rst_in_ready5", W'(ir5), W'(1));
        chk("rst_result5", res5, '0);

        // Directed vectors on both digit sizes.
        for (int i = 0; i < 10; i++) begin
            run_check(1'b0, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].exp);
            run_check(1'b1, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].exp);
        end

        // DONE held with out_ready low; in_valid pulses must be ignored.
        out_ready = 1'b0;
        start_op(1'b0, B162, 163'd2, GPOLY);
        wait_done(1'b0, lat);
        chk("hold_latency", W'(lat), W'(41));
        saved = res4;
        chk("hold_result", saved, 163'hC9);
        for (int i = 0; i < 5; i++) begin
            iv4 = 1'b1; a = rnd163(); b = rnd163(); g = rnd163();
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", W'(ov4), W'(1));
            chk("hold_in_ready", W'(ir4), W'(0));
            chk("hold_stable", res4, 163'hC9);
        end
        iv4 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_out_valid", W'(ov4), W'(0));
        chk("release_in_ready", W'(ir4), W'(1));
        chk("release_busy", W'(busy4), W'(0));

        // Reset in the middle of RUN.
        start_op(1'b0, rnd163() | 163'd1, ~163'd0, GPOLY);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_in_ready", W'(ir4), W'(1));
        chk("midrst_out_valid", W'(ov4), W'(0));
        chk("midrst_busy", W'(busy4), W'(0));
        chk("midrst_result", res4, '0);
        run_check(1'b0, 163'd3, 163'd3, GPOLY, 163'd5);

        // Random operands against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = rnd163(); rb = rnd163();
            run_check(1'b0, ra, rb, GPOLY, ref_mul(ra, rb, GPOLY));
        end
        for (int i = 0; i < 100; i++) begin
            ra = rnd163(); rb = rnd163();
            rg = (i % 2 == 0) ? GPOLY : rnd163();
            run_check(1'b1, ra, rb, rg, ref_mul(ra, rb, rg));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
